// File: rtl/spi_slave_reg_ctrl.sv
// Command/register sequencer for an SPI slave byte interface: decodes a command byte per
// chip-select transaction and runs auto-incrementing register writes/reads in the i_Clk domain.
module spi_slave_reg_ctrl #(
  parameter int unsigned ADDR_W     = 7,
  parameter int unsigned RD_TIMEOUT = 15,
  parameter logic [7:0]  ERR_BYTE   = 8'hEE,
  parameter logic [3:0]  STATUS_ID  = 4'hA
) (
  input  logic              i_Clk,
  input  logic              i_Rst_L,
  input  logic              i_RX_DV,
  input  logic [7:0]        i_RX_Byte,
  output logic              o_TX_DV,
  output logic [7:0]        o_TX_Byte,
  input  logic              i_SPI_CS_n,
  output logic [ADDR_W-1:0] o_Reg_Addr,
  output logic              o_Reg_WE,
  output logic [7:0]        o_Reg_WData,
  output logic              o_Reg_RE,
  input  logic [7:0]        i_Reg_RData,
  input  logic              i_Reg_RValid,
  output logic              o_Busy
);

  localparam int unsigned CntW = $clog2(RD_TIMEOUT + 1);

  typedef enum logic [2:0] {StIdle, StCmd, StWrData, StRdWait, StRdData} state_e;

  state_e            state_q;
  logic              cs_meta_q, cs_sync_q, cs_prev_q;
  logic [ADDR_W-1:0] addr_q;
  logic [CntW-1:0]   cnt_q;
  logic              overrun_q, timeout_q;
  logic              preload_q;
  logic              cs_fall, cs_rise;
  logic [7:0]        status;

  assign cs_fall = cs_prev_q & ~cs_sync_q;
  assign cs_rise = ~cs_prev_q & cs_sync_q;
  assign status  = {STATUS_ID, 2'b00, overrun_q, timeout_q};
  assign o_Busy  = ~cs_sync_q;

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_q     <= StIdle;
      cs_meta_q   <= 1'b1;
      cs_sync_q   <= 1'b1;
      cs_prev_q   <= 1'b1;
      addr_q      <= '0;
      cnt_q       <= '0;
      overrun_q   <= 1'b0;
      timeout_q   <= 1'b0;
      preload_q   <= 1'b1;
      o_TX_DV     <= 1'b0;
      o_TX_Byte   <= 8'h00;
      o_Reg_Addr  <= '0;
      o_Reg_WE    <= 1'b0;
      o_Reg_WData <= 8'h00;
      o_Reg_RE    <= 1'b0;
    end else begin
      cs_meta_q <= i_SPI_CS_n;
      cs_sync_q <= cs_meta_q;
      cs_prev_q <= cs_sync_q;
      o_TX_DV   <= 1'b0;
      o_Reg_WE  <= 1'b0;
      o_Reg_RE  <= 1'b0;

      // Status preload goes out once after reset and once after every transaction end
      if (preload_q) begin
        o_TX_DV   <= 1'b1;
        o_TX_Byte <= status;
        preload_q <= 1'b0;
      end

      unique case (state_q)
        StIdle: begin
          if (cs_fall) state_q <= StCmd;
        end
        StCmd: begin
          if (i_RX_DV) begin
            addr_q    <= i_RX_Byte[ADDR_W-1:0];
            overrun_q <= 1'b0;
            timeout_q <= 1'b0;
            if (i_RX_Byte[7]) begin
              o_Reg_RE   <= 1'b1;
              o_Reg_Addr <= i_RX_Byte[ADDR_W-1:0];
              cnt_q      <= '0;
              state_q    <= StRdWait;
            end else begin
              state_q <= StWrData;
            end
          end
        end
        StWrData: begin
          if (i_RX_DV) begin
            o_Reg_WE    <= 1'b1;
            o_Reg_WData <= i_RX_Byte;
            o_Reg_Addr  <= addr_q;
            addr_q      <= addr_q + ADDR_W'(1);
          end
        end
        StRdWait: begin
          if (i_RX_DV) overrun_q <= 1'b1;
          // Valid data beats a coincident timeout
          if (i_Reg_RValid) begin
            o_TX_DV   <= 1'b1;
            o_TX_Byte <= i_Reg_RData;
            addr_q    <= addr_q + ADDR_W'(1);
            state_q   <= StRdData;
          end else if (cnt_q == CntW'(RD_TIMEOUT)) begin
            o_TX_DV   <= 1'b1;
            o_TX_Byte <= ERR_BYTE;
            timeout_q <= 1'b1;
            addr_q    <= addr_q + ADDR_W'(1);
            state_q   <= StRdData;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        StRdData: begin
          if (i_RX_DV) begin
            o_Reg_RE   <= 1'b1;
            o_Reg_Addr <= addr_q;
            cnt_q      <= '0;
            state_q    <= StRdWait;
          end
        end
        default: state_q <= StIdle;
      endcase

      // Transaction end: a same-cycle write byte still strobes, read activity is dropped
      if (cs_rise) begin
        state_q   <= StIdle;
        preload_q <= 1'b1;
        if (state_q inside {StCmd, StRdWait, StRdData}) begin
          o_TX_DV  <= 1'b0;
          o_Reg_RE <= 1'b0;
        end
      end
    end
  end

endmodule
